// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op codes, default latencies,
// and the instruction class the stall controller uses to hold D behind the MDU.
package mdu_pkg;

  localparam int MDU_WIDTH_DEF       = 32;
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  // IDLE is counter==0, RUN is counter!=0.
  localparam logic [0:0] MDU_ST_IDLE = 1'b0;
  localparam logic [0:0] MDU_ST_RUN  = 1'b1;

  typedef enum logic [2:0] {
    MDU_CLS_NONE,
    MDU_CLS_MULT,
    MDU_CLS_DIV,
    MDU_CLS_MFHI,
    MDU_CLS_MFLO,
    MDU_CLS_MTHI,
    MDU_CLS_MTLO
  } mdu_class_e;

  // Stall D when an MDU-class instruction sits there and the unit is busy or starting.
  function automatic logic mdu_stall_d(mdu_class_e d_cls, logic busy, logic e_start);
    return (d_cls != MDU_CLS_NONE) && (busy || e_start);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage operand/command bundle and HI/LO result bundle of the MDU.
// Handshake: start is a one-cycle request sampled on the rising clk edge and
// taken only when busy=0; with busy=1 it is dropped, so the issuer must hold off.
interface mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [0:0]       dbg_state;

  modport master (output start, op, a, b, input busy, hi, lo, dbg_state);
  modport slave  (input start, op, a, b, output busy, hi, lo, dbg_state);
endinterface

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider: quotient truncates toward zero and the
// remainder takes the dividend's sign. Flags divide-by-zero and MIN/-1 overflow.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             div_zero_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag;

  assign a_neg      = signed_i & a_i[WIDTH-1];
  assign b_neg      = signed_i & b_i[WIDTH-1];
  assign a_mag      = a_neg ? -a_i : a_i;
  assign b_mag      = b_neg ? -b_i : b_i;
  assign div_zero_o = (b_i == '0);
  // Keep the divider defined on a zero divisor; the result is discarded anyway.
  assign b_safe     = div_zero_o ? ONE : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot_o     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem_o      = a_neg ? -r_mag : r_mag;
  assign ovf_o      = signed_i && (a_i == MOST_NEG) && (b_i == '1);

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: computes in the accepting cycle, holds the result in
// pending registers, and commits to HI/LO after a fixed busy period.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH_DEF,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;
  logic               mul_signed;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH-1:0]   div_quot, div_rem;
  logic               div_zero, div_ovf;

  // Low 2W bits of a product of sign-extended operands equal the signed product.
  assign mul_signed = (bus.op == MDU_MULT);
  assign mul_a = mul_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign mul_b = mul_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign prod  = mul_a * mul_b;

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .a_i       (bus.a),
    .b_i       (bus.b),
    .signed_i  (bus.op == MDU_DIV),
    .quot_o    (div_quot),
    .rem_o     (div_rem),
    .div_zero_o(div_zero),
    .ovf_o     (div_ovf)
  );

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
      if ((cnt_q == CNT_ONE) && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (bus.start) begin
      case (bus.op)
        MDU_MULT, MDU_MULTU: begin
          pend_hi_d = prod[2*WIDTH-1:WIDTH];
          pend_lo_d = prod[WIDTH-1:0];
          pend_wr_d = 1'b1;
          cnt_d     = MULT_LAT;
        end
        MDU_DIV, MDU_DIVU: begin
          // MIN / -1 wraps to MIN with a zero remainder.
          pend_hi_d = div_ovf ? '0 : div_rem;
          pend_lo_d = div_ovf ? bus.a : div_quot;
          pend_wr_d = !div_zero;
          cnt_d     = DIV_LAT;
        end
        MDU_MTHI: hi_d = bus.a;
        MDU_MTLO: lo_d = bus.a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign bus.busy      = (cnt_q != '0);
  assign bus.dbg_state = (cnt_q != '0) ? MDU_ST_RUN : MDU_ST_IDLE;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a reference model pushes expected {hi,lo} on issue and
// the checker pops it when busy falls; a second instance runs MULT_CYCLES=1.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   viol = 0;
  logic [W-1:0]   mdl_hi = '0;
  logic [W-1:0]   mdl_lo = '0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_v;

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus0 ();
  mdu_if #(.WIDTH(W)) bus1 ();

  mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk(clk), .reset(rst), .bus(bus0)
  );
  mdu #(.WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(10)) u_dut1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );

  // Issuing while busy breaks the stall contract; note it so the run shows it was deliberate.
  always @(posedge clk) begin
    if (!rst && bus0.start && bus0.busy) begin
      viol++;
      $display("note: start while busy at %0t (protocol violation, must be ignored)", $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model, written from the architectural definition.
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      MDU_MULT:  begin p = 64'($signed(longint'(sa) * longint'(sb))); mdl_hi = p[2*W-1:W]; mdl_lo = p[W-1:0]; end
      MDU_MULTU: begin p = {32'b0, a} * {32'b0, b}; mdl_hi = p[2*W-1:W]; mdl_lo = p[W-1:0]; end
      MDU_DIV: begin
        if (b == '0) begin end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mdl_lo = a; mdl_hi = '0; end
        else begin mdl_lo = W'(sa / sb); mdl_hi = W'(sa % sb); end
      end
      MDU_DIVU: if (b != '0) begin mdl_lo = a / b; mdl_hi = a % b; end
      default: ;
    endcase
    exp_q.push_back({mdl_hi, mdl_lo});
  endtask

  task automatic pop_check(input string tag);
    chk({tag, "_qlen"}, W'(exp_q.size()), W'(1));
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      chk({tag, "_hi"}, bus0.hi, exp_v[2*W-1:W]);
      chk({tag, "_lo"}, bus0.lo, exp_v[W-1:0]);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat);
    bus0.start = 1'b1; bus0.op = op; bus0.a = a; bus0.b = b;
    tick();
    bus0.start = 1'b0; bus0.op = MDU_NONE;
    model_op(op, a, b);
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_busy"}, W'(bus0.busy), W'(1));
      tick();
    end
    chk({tag, "_idle"}, W'(bus0.busy), W'(0));
    pop_check(tag);
  endtask

  initial begin
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    bus0.start = 1'b0; bus0.op = MDU_NONE; bus0.a = '0; bus0.b = '0;
    bus1.start = 1'b0; bus1.op = MDU_NONE; bus1.a = '0; bus1.b = '0;
    repeat (2) tick();
    chk("rst_busy", W'(bus0.busy), W'(0));
    chk("rst_hi", bus0.hi, '0);
    chk("rst_lo", bus0.lo, '0);
    chk("rst_busy1", W'(bus1.busy), W'(0));
    rst = 1'b0;
    tick();

    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 5);
    chk("mult_neg_lo_const", bus0.lo, 32'hFFFF_FFEB);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
    chk("multu_hi_const", bus0.hi, 32'h0000_0001);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_neg_lo_const", bus0.lo, 32'hFFFF_FFFD);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("div_ovf_lo_const", bus0.lo, 32'h8000_0000);

    // MTHI lands one cycle later, then a divide by zero must leave HI/LO alone.
    bus0.start = 1'b1; bus0.op = MDU_MTHI; bus0.a = 32'h1234_5678;
    tick();
    bus0.start = 1'b0; bus0.op = MDU_NONE;
    mdl_hi = 32'h1234_5678;
    chk("mthi_hi", bus0.hi, 32'h1234_5678);
    chk("mthi_busy", W'(bus0.busy), W'(0));
    bus0.start = 1'b1; bus0.op = MDU_MTLO; bus0.a = 32'h0BAD_F00D;
    tick();
    bus0.start = 1'b0; bus0.op = MDU_NONE;
    mdl_lo = 32'h0BAD_F00D;
    chk("mtlo_lo", bus0.lo, 32'h0BAD_F00D);
    run_op("divu_zero", MDU_DIVU, 32'd7, 32'd0, 10);
    chk("divu_zero_hi_const", bus0.hi, 32'h1234_5678);

    // Op codes 0 and 7 do nothing even with start.
    bus0.start = 1'b1; bus0.op = 3'd7; bus0.a = 32'hDEAD_BEEF; bus0.b = 32'd3;
    tick();
    bus0.start = 1'b0; bus0.op = MDU_NONE;
    chk("op7_busy", W'(bus0.busy), W'(0));
    chk("op7_hi", bus0.hi, mdl_hi);
    chk("op7_lo", bus0.lo, mdl_lo);

    // A MULT issued on the DIV's third busy cycle is dropped.
    bus0.start = 1'b1; bus0.op = MDU_DIV; bus0.a = 32'd100; bus0.b = 32'd7;
    tick();
    model_op(MDU_DIV, 32'd100, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        bus0.start = 1'b1; bus0.op = MDU_MULT; bus0.a = 32'd1; bus0.b = 32'd1;
      end else begin
        bus0.start = 1'b0; bus0.op = MDU_NONE;
      end
      chk("ign_busy", W'(bus0.busy), W'(1));
      tick();
    end
    chk("ign_idle", W'(bus0.busy), W'(0));
    pop_check("ign");
    chk("ign_lo_const", bus0.lo, 32'd14);
    chk("viol_count", W'(viol), W'(1));
    run_op("b2b_mult", MDU_MULT, 32'd1, 32'd1, 5);

    for (int k = 0; k < 6; k++) begin
      rop = 3'(1 + (k % 4));
      ra  = $urandom;
      rb  = $urandom_range(1, 32'h7FFF_FFFF);
      if (k == 5) ra = 32'h8000_0001;
      run_op("rand", rop, ra, rb, (rop <= MDU_MULTU) ? 5 : 10);
    end

    // Single-cycle multiply instance.
    bus1.start = 1'b1; bus1.op = MDU_MULTU; bus1.a = 32'hFFFF_FFFF; bus1.b = 32'd2;
    tick();
    bus1.start = 1'b0; bus1.op = MDU_NONE;
    chk("m1_busy", W'(bus1.busy), W'(1));
    chk("m1_hi_old", bus1.hi, 32'd0);
    tick();
    chk("m1_idle", W'(bus1.busy), W'(0));
    chk("m1_hi", bus1.hi, 32'h0000_0001);
    chk("m1_lo", bus1.lo, 32'hFFFF_FFFE);

    // Asynchronous reset mid-multiply discards the pending result.
    run_op("pre_rst", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    bus0.start = 1'b1; bus0.op = MDU_MULT; bus0.a = 32'd3; bus0.b = 32'd5;
    tick();
    bus0.start = 1'b0; bus0.op = MDU_NONE;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", W'(bus0.busy), W'(0));
    chk("arst_hi", bus0.hi, 32'd0);
    chk("arst_lo", bus0.lo, 32'd0);
    mdl_hi = '0;
    mdl_lo = '0;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("post_rst_busy", W'(bus0.busy), W'(0));
    chk("post_rst_hi", bus0.hi, 32'd0);
    chk("post_rst_lo", bus0.lo, 32'd0);
    run_op("post_rst_mult", MDU_MULT, 32'd6, 32'hFFFF_FFFE, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multiply/divide unit for the five-stage pipeline, sitting beside the ALU in the E stage. It executes MULT/MULTU/DIV/DIVU over a configurable number of cycles and MTHI/MTLO in one cycle, and owns the HI/LO architectural registers. `busy` drives the stall controller so that any MDU-class instruction in D holds while an operation is in flight.

## Interface
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for MULT/MULTU; legal range ≥1.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock; the block has exactly one clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  accept `op` this cycle; ignored while `busy`=1.
- op  input  3  operation code, defined in the shared package.
- a  input  WIDTH  forwarded rs value, E stage.
- b  input  WIDTH  forwarded rt value, E stage.
- busy  output  1  multi-cycle operation in flight.
- hi  output  WIDTH  HI register, for MFHI.
- lo  output  WIDTH  LO register, for MFLO.

## Operation
- Op codes:
  - MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Codes 7 and MDU_NONE are no-ops even with `start`=1.
- Reset values: hi=0, lo=0, busy=0, counter=0, pending results=0.
- States:
  - IDLE (counter==0) and RUN (counter!=0).
  - busy = (counter != 0), decoded directly from registered state.
- IDLE, start=1 with MULT/MULTU/DIV/DIVU:
  - Compute the result from a and b in the accepting cycle and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN: counter decrements each cycle. When counter==1, commit pending to hi/lo at that edge; counter becomes 0 and the block returns to IDLE.
- MTHI/MTLO in IDLE: hi←a or lo←a at the next edge; busy stays 0.
- start while busy: ignored entirely; hi/lo and pending are untouched. The bench flags this as a protocol violation, because the stall controller must prevent it.
- Arithmetic:
  - MULT: signed 2·WIDTH product; hi=upper half, lo=lower half.
  - MULTU: same product, unsigned.
  - DIV: lo=quotient truncated toward zero; hi=remainder carrying the sign of the dividend.
  - DIV with a=most-negative and b=−1: lo=a, hi=0, by wrap-around.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (DIV or DIVU): a full DIV_CYCLES busy period still runs, but hi/lo are left unchanged at commit.
- hi and lo are plain register outputs. The W-stage write-back mux reads them; there is no read port handshake.

## Timing
- Start sampled at edge t, with op in {MULT, MULTU, DIV, DIVU} and LAT its latency:
  - busy=1 in cycles t+1 through t+LAT.
  - New hi/lo are visible from cycle t+LAT+1, the same cycle busy falls.
- Back-to-back: a new start can be sampled in the first cycle busy=0.
- MTHI/MTLO sampled at edge t: the new value is visible in cycle t+1.
- Reset asserted mid-operation: busy, hi and lo drop to 0 asynchronously, and the pending result is discarded. After reset deasserts, the first edge may accept a start.
- Stall contract, implemented in the stall controller: stall D when the D instruction is MDU-class (mult/div/mfhi/mflo/mthi/mtlo) and either (busy=1) or (start=1 in E).

## Structure
- Shared constants package (alongside the existing constants file) holds:
  - the MDU_* op codes;
  - the default MULT_CYCLES/DIV_CYCLES;
  - the MDU-class instruction type used by the stall controller.
- One natural sub-module is `mdu_divider`: combinational signed/unsigned quotient and remainder, with divide-by-zero and overflow flags.
- The multiply is an inline `*` on sign- or zero-extended 2·WIDTH operands.
- The top level holds the counter, the pending registers and HI/LO.

## Test plan
- MULT with a=0xFFFFFFFD and b=7 → busy high exactly 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFEB.
- MULTU with a=0xFFFFFFFF and b=2 → hi=0x00000001 and lo=0xFFFFFFFE. Also rerun with MULT_CYCLES=1 and check busy is high for exactly one cycle.
- Divide cases:
  - DIV with a=0xFFFFFFF9 (−7) and b=2 → after 10 busy cycles, lo=0xFFFFFFFD and hi=0xFFFFFFFF.
  - DIV with a=0x80000000 and b=0xFFFFFFFF → lo=0x80000000 and hi=0.
- MTHI with a=0x12345678, then DIVU with a=7 and b=0 → hi=0x12345678 in the cycle after MTHI. Then busy runs 10 cycles and hi=0x12345678 and lo are unchanged afterwards.
- Start a DIV, then on busy's 3rd cycle assert start with MULT a=1 b=1 → the MULT is ignored and the DIV result commits on schedule. A MULT started the cycle busy falls is accepted.
- Start a MULT, then assert reset asynchronously mid-cycle on busy's 2nd cycle → busy, hi and lo read 0 before the next edge. After reset releases, no stale commit occurs.
